sram_frame_scanout: RTL



---
 rtl/sram_scanout_pkg.sv | 26 ++
 rtl/scanout_skid_fifo.sv | 72 +++++++
 rtl/sram_frame_scanout.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_scanout_pkg.sv
// Shared types for the SRAM framebuffer scanout engine: SRAM strobe encodings,
// scanout FSM states and the RGB565 -> RGB888 expansion.
package sram_scanout_pkg;

  typedef struct packed {
    logic oe_n;
    logic we_n;
    logic ce_n;
  } sram_ctrl_t;

  localparam sram_ctrl_t SRAM_IDLE = '{oe_n: 1'b1, we_n: 1'b1, ce_n: 1'b1};
  localparam sram_ctrl_t SRAM_READ = '{oe_n: 1'b0, we_n: 1'b1, ce_n: 1'b0};

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } scan_state_t;

  // Replicate the top bits into the new LSBs so full scale maps to full scale.
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

endpackage

// File: rtl/scanout_skid_fifo.sv
// Small register FIFO that absorbs SRAM reads still in flight when the
// downstream pixel FIFO stalls. Depth need not be a power of two.
module scanout_skid_fifo #(
  parameter  int DEPTH = 3,
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CNT_W-1:0] free_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty      = (count_q == '0);
  assign free_count = CNT_W'(DEPTH) - count_q;
  assign dout       = mem_q[rd_ptr_q];

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the reset pointers and count
  // already mark it empty, and leaving it out keeps it as plain registers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/sram_frame_scanout.sv
// Framebuffer scanout: walks an H_ACTIVE x V_ACTIVE window of 16-bit SRAM and
// writes RGB888 pixels to the video FIFO. Define SRAM_FRAME_SCANOUT_PATTERN_EN
// to replace SRAM reads with a synthetic {x[4:0], y[5:0], x[9:5]} test pattern.
module sram_frame_scanout
  import sram_scanout_pkg::*;
#(
  parameter int H_ACTIVE        = 800,
  parameter int V_ACTIVE        = 480,
  parameter int STRIDE          = 800,
  parameter int ADDR_W          = 20,
  parameter int READ_LATENCY    = 1,
  parameter int POST_RESET_WAIT = 15
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              busy,
  output logic              overrun,
  output logic [23:0]       fifo_data,
  output logic              fifo_wrreq,
  input  logic              fifo_wrfull,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [15:0]       sram_dq,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ce_n
);

  localparam int X_W        = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W        = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int SKID_DEPTH = READ_LATENCY + 2;
  localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
  localparam int WAIT_W     = (POST_RESET_WAIT > 1) ? $clog2(POST_RESET_WAIT) : 1;

  scan_state_t              state_q, state_d;
  logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [X_W-1:0]           x_q, x_d;
  logic [Y_W-1:0]           y_q, y_d;
  logic [ADDR_W-1:0]        pix_addr_q, pix_addr_d;
  logic [ADDR_W-1:0]        line_addr_q, line_addr_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic [ADDR_W-1:0]        sram_addr_q, sram_addr_d;
  sram_ctrl_t               ctrl_q, ctrl_d;
  logic [READ_LATENCY-1:0]  tok_q, tok_d;
  logic [23:0]              fifo_data_q, fifo_data_d;
  logic                     fifo_wrreq_q, fifo_wrreq_d;

  logic                     issue;
  logic [X_W-1:0]           cur_x;
  logic [Y_W-1:0]           cur_y;
  logic [ADDR_W-1:0]        cur_pix, cur_line;
  logic                     skid_pop, skid_empty;
  logic [CNT_W-1:0]         skid_free;
  logic [15:0]              skid_din, skid_dout;

  assign sram_dq = 16'hzzzz;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_addr_d  = pix_addr_q;
    line_addr_d = line_addr_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    issue       = 1'b0;
    cur_x       = x_q;
    cur_y       = y_q;
    cur_pix     = pix_addr_q;
    cur_line    = line_addr_q;

    unique case (state_q)
      WAIT: begin
        if (int'(wait_cnt_q) >= POST_RESET_WAIT - 1) state_d = IDLE;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      IDLE: begin
        // The first read goes out straight from IDLE so it lands one cycle
        // after frame_start.
        if (frame_start) begin
          busy_d   = 1'b1;
          cur_x    = '0;
          cur_y    = '0;
          cur_pix  = frame_base;
          cur_line = frame_base;
          issue    = 1'b1;
        end
      end
      // A read is only launched when the skid is guaranteed room for it and
      // every read already in flight, so a stall can never drop data.
      ACTIVE: issue = (int'(skid_free) > $countones(tok_q));
      DRAIN: begin
        if (tok_q == '0 && skid_empty) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = WAIT;
    endcase

    if (busy_q && frame_start) overrun_d = 1'b1;

    if (issue) begin
      if (cur_x == X_W'(H_ACTIVE - 1)) begin
        x_d         = '0;
        y_d         = cur_y + 1'b1;
        line_addr_d = cur_line + ADDR_W'(STRIDE);
        pix_addr_d  = cur_line + ADDR_W'(STRIDE);
        state_d     = (cur_y == Y_W'(V_ACTIVE - 1)) ? DRAIN : ACTIVE;
      end else begin
        x_d         = cur_x + 1'b1;
        y_d         = cur_y;
        line_addr_d = cur_line;
        pix_addr_d  = cur_pix + 1'b1;
        state_d     = ACTIVE;
      end
    end

    tok_d[0] = issue;
    for (int i = 1; i < READ_LATENCY; i++) tok_d[i] = tok_q[i-1];

`ifdef SRAM_FRAME_SCANOUT_PATTERN_EN
    ctrl_d      = SRAM_IDLE;
    sram_addr_d = '0;
`else
    ctrl_d      = issue ? SRAM_READ : SRAM_IDLE;
    sram_addr_d = issue ? cur_pix : '0;
`endif

    skid_pop     = !skid_empty && !fifo_wrfull;
    fifo_wrreq_d = skid_pop;
    fifo_data_d  = skid_pop ? rgb565_to_rgb888(skid_dout) : fifo_data_q;
  end

`ifdef SRAM_FRAME_SCANOUT_PATTERN_EN
  logic [15:0] pat_q [READ_LATENCY];
  logic [15:0] pat_d [READ_LATENCY];
  logic [9:0]  pat_x, pat_y;

  always_comb begin
    pat_x    = 10'(cur_x);
    pat_y    = 10'(cur_y);
    pat_d[0] = {pat_x[4:0], pat_y[5:0], pat_x[9:5]};
    for (int i = 1; i < READ_LATENCY; i++) pat_d[i] = pat_q[i-1];
  end

  always_ff @(posedge clk) begin
    pat_q <= pat_d;
  end

  assign skid_din = pat_q[READ_LATENCY-1];
`else
  assign skid_din = sram_dq;
`endif

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= WAIT;
      wait_cnt_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pix_addr_q   <= '0;
      line_addr_q  <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      sram_addr_q  <= '0;
      ctrl_q       <= SRAM_IDLE;
      tok_q        <= '0;
      fifo_data_q  <= '0;
      fifo_wrreq_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pix_addr_q   <= pix_addr_d;
      line_addr_q  <= line_addr_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      sram_addr_q  <= sram_addr_d;
      ctrl_q       <= ctrl_d;
      tok_q        <= tok_d;
      fifo_data_q  <= fifo_data_d;
      fifo_wrreq_q <= fifo_wrreq_d;
    end
  end

  // The oldest token marks the edge where its read data is valid on sram_dq.
  scanout_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (16)
  ) u_skid (
    .clk        (clk),
    .areset_n   (areset_n),
    .push       (tok_q[READ_LATENCY-1]),
    .pop        (skid_pop),
    .din        (skid_din),
    .dout       (skid_dout),
    .empty      (skid_empty),
    .free_count (skid_free)
  );

  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign fifo_data  = fifo_data_q;
  assign fifo_wrreq = fifo_wrreq_q;
  assign sram_addr  = sram_addr_q;
  assign sram_oe_n  = ctrl_q.oe_n;
  assign sram_we_n  = ctrl_q.we_n;
  assign sram_ce_n  = ctrl_q.ce_n;

endmodule
